mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port 16-bit memory between the CPU fetch stage (read-only) and the load/store stage (read/write). Sits between the cpu core ports (pc and ldst) and the memory. Arbitrates per cycle, holds a granted request through memory wait-states, and routes read data back to the owner one cycle after acceptance. Returns a wait signal so the pipeline can stall.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
STREAK_MAX, 4, consecutive ldst grants allowed before a pending fetch is forced (only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_f_addr  in  ADDR_W  fetch address
i_f_rd  in  1  fetch read request
o_f_wait  out  1  fetch request not accepted this cycle; hold the request
o_f_rddata  out  DATA_W  fetch read data
o_f_rdvalid  out  1  o_f_rddata valid
i_ls_addr  in  ADDR_W  load/store address
i_ls_rd  in  1  load request
i_ls_wr  in  1  store request
i_ls_wrdata  in  DATA_W  store data
o_ls_wait  out  1  ldst request not accepted this cycle; hold the request
o_ls_rddata  out  DATA_W  load read data
o_ls_rdvalid  out  1  o_ls_rddata valid
o_mem_addr  out  ADDR_W  memory address
o_mem_rd  out  1  memory read strobe
o_mem_wr  out  1  memory write strobe
o_mem_wrdata  out  DATA_W  memory write data
i_mem_waitrequest  in  1  memory stalls the current command
i_mem_rddata  in  DATA_W  read data, valid the cycle after an accepted read

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named reset.
- Reset: state IDLE; o_f_rdvalid = 0, o_ls_rdvalid = 0; return-owner register cleared; streak counter = 0. Memory strobes are 0 while reset is high.
- ldst request: i_ls_rd | i_ls_wr. If both are set, the write wins and the read is ignored.
- States:
  - IDLE: grant ldst if it requests, else grant fetch if it requests. Drive the granted master's addr/strobes/wrdata onto o_mem_* combinationally in the same cycle.
    - If i_mem_waitrequest = 0, the command is accepted; stay in IDLE.
    - If i_mem_waitrequest = 1, go to HOLD_LS or HOLD_F.
  - HOLD_LS / HOLD_F: keep the grant locked to the same master. Mux that master's current inputs to memory. Return to IDLE in the cycle waitrequest = 0.
  - A master must hold its request stable while its wait is high. Dropping a request in a HOLD state is illegal.
- Wait outputs:
  - o_X_wait = requesting & ~(granted & ~i_mem_waitrequest).
  - A non-requesting master sees wait = 0.
  - The losing master sees wait = 1.
- Read return: on an accepted read, register the owner (F or LS). In the next cycle assert o_<owner>_rdvalid = 1 for exactly one cycle with rddata = i_mem_rddata. The other rdvalid stays 0. Writes produce no rdvalid.
- Back-to-back: a new command may issue in the cycle a previous read's data returns (throughput 1/cycle). Return ordering is preserved.
- o_f_rddata and o_ls_rddata always show i_mem_rddata. Only the rdvalid flags differ.
- Reset mid-transaction (including a HOLD state or a pending return): abandon the command; no rdvalid is asserted the following cycle.

Optional Feature:
Macro ARB_FAIRNESS_EN.
- Defined: a streak counter (width $clog2(STREAK_MAX+1)) increments on each accepted ldst grant while i_f_rd is pending. It clears on an accepted fetch or when i_f_rd = 0. When streak == STREAK_MAX and fetch is pending, IDLE grants fetch over ldst once.
- Undefined: ldst has strict priority and fetch may starve; no counter logic.

Test Plan:
- Fetch only, addr 0x0010, waitrequest 0, rddata 0x1234 next cycle -> o_mem_rd = 1 and o_f_wait = 0 in cycle 0; o_f_rdvalid = 1 with 0x1234 in cycle 1; o_ls_rdvalid = 0.
- Simultaneous fetch 0x0020 and store 0x0100 = 0xBEEF -> cycle 0: o_mem_wr = 1, addr 0x0100, o_f_wait = 1. Cycle 1: fetch issued. Cycle 2: o_f_rdvalid = 1.
- Load 0x0200 with waitrequest high for 3 cycles while fetch requests -> grant held on ldst, o_ls_wait = 1 for 3 cycles, fetch blocked. Load is accepted in cycle 3; o_ls_rdvalid in cycle 4.
- Alternating accepted load/fetch every cycle -> rdvalid owners follow issue order with no lost or duplicated data.
- Reset asserted in the cycle after an accepted read -> no rdvalid either side; outputs return to reset values.
- With ARB_FAIRNESS_EN and STREAK_MAX = 4: continuous loads plus pending fetch -> the 5th grant goes to fetch, then loads resume. Without the macro, fetch waits indefinitely.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (read-only) and load/store (read/write); command in the same cycle, read data one cycle after acceptance.
// Backpressure: per-master wait holds requests; grant is locked through memory wait-states. Optional fetch fairness: ARB_FAIRNESS_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_f_addr,
    input  logic              i_f_rd,
    output logic              o_f_wait,
    output logic [DATA_W-1:0] o_f_rddata,
    output logic              o_f_rdvalid,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic              i_ls_rd,
    input  logic              i_ls_wr,
    input  logic [DATA_W-1:0] i_ls_wrdata,
    output logic              o_ls_wait,
    output logic [DATA_W-1:0] o_ls_rddata,
    output logic              o_ls_rdvalid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_wrdata,
    input  logic              i_mem_waitrequest,
    input  logic [DATA_W-1:0] i_mem_rddata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD_LS = 2'd1,
        ST_HOLD_F  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ret_f_q, ret_f_d;
    logic   ret_ls_q, ret_ls_d;
    logic   ls_req, ls_wr, ls_rd;
    logic   grant_ls, grant_f;
    logic   acc_ls, acc_f;
    logic   force_f;

    // A simultaneous read and write from load/store is treated as a write.
    assign ls_req = i_ls_rd | i_ls_wr;
    assign ls_wr  = i_ls_wr;
    assign ls_rd  = i_ls_rd & ~i_ls_wr;

`ifdef ARB_FAIRNESS_EN
    localparam int STREAK_W = $clog2(STREAK_MAX + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;

    assign force_f = i_f_rd && (streak_q == STREAK_W'(STREAK_MAX));

    always_comb begin
        streak_d = streak_q;
        if (acc_f || !i_f_rd) begin
            streak_d = '0;
        end else if (acc_ls && (streak_q != STREAK_W'(STREAK_MAX))) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign force_f = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_ls = 1'b0;
        grant_f  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_ls = ls_req & ~force_f;
                grant_f  = i_f_rd & ~grant_ls;
                if (i_mem_waitrequest) begin
                    if (grant_ls) begin
                        state_d = ST_HOLD_LS;
                    end else if (grant_f) begin
                        state_d = ST_HOLD_F;
                    end
                end
            end
            ST_HOLD_LS: begin
                grant_ls = 1'b1;
                if (!i_mem_waitrequest) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD_F: begin
                grant_f = 1'b1;
                if (!i_mem_waitrequest) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign acc_ls = grant_ls & ~i_mem_waitrequest;
    assign acc_f  = grant_f  & ~i_mem_waitrequest;

    // Return owner for the read accepted this cycle; writes leave both clear.
    assign ret_f_d  = acc_f  & i_f_rd;
    assign ret_ls_d = acc_ls & ls_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ret_f_q  <= 1'b0;
            ret_ls_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_f_q  <= ret_f_d;
            ret_ls_q <= ret_ls_d;
        end
    end

    always_comb begin
        o_mem_addr   = grant_ls ? i_ls_addr : i_f_addr;
        o_mem_wrdata = i_ls_wrdata;
        o_mem_rd     = ~reset & ((grant_ls & ls_rd) | (grant_f & i_f_rd));
        o_mem_wr     = ~reset & grant_ls & ls_wr;
    end

    assign o_f_wait     = i_f_rd & ~acc_f;
    assign o_ls_wait    = ls_req & ~acc_ls;
    assign o_f_rddata   = i_mem_rddata;
    assign o_ls_rddata  = i_mem_rddata;
    // A pending return is dropped as soon as reset is seen.
    assign o_f_rdvalid  = ret_f_q  & ~reset;
    assign o_ls_rdvalid = ret_ls_q & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, wait-state hold, read return routing, reset abort, fetch fairness.
module tb_mem_port_arbiter;

`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] i_f_addr;
    logic        i_f_rd;
    logic        o_f_wait;
    logic [15:0] o_f_rddata;
    logic        o_f_rdvalid;
    logic [15:0] i_ls_addr;
    logic        i_ls_rd;
    logic        i_ls_wr;
    logic [15:0] i_ls_wrdata;
    logic        o_ls_wait;
    logic [15:0] o_ls_rddata;
    logic        o_ls_rdvalid;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic [15:0] o_mem_wrdata;
    logic        i_mem_waitrequest;
    logic [15:0] i_mem_rddata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STREAK_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .i_f_addr(i_f_addr), .i_f_rd(i_f_rd), .o_f_wait(o_f_wait),
        .o_f_rddata(o_f_rddata), .o_f_rdvalid(o_f_rdvalid),
        .i_ls_addr(i_ls_addr), .i_ls_rd(i_ls_rd), .i_ls_wr(i_ls_wr),
        .i_ls_wrdata(i_ls_wrdata), .o_ls_wait(o_ls_wait),
        .o_ls_rddata(o_ls_rddata), .o_ls_rdvalid(o_ls_rdvalid),
        .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
        .o_mem_wrdata(o_mem_wrdata), .i_mem_waitrequest(i_mem_waitrequest),
        .i_mem_rddata(i_mem_rddata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_f_rd            = 1'b0;
        i_ls_rd           = 1'b0;
        i_ls_wr           = 1'b0;
        i_mem_waitrequest = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        i_f_addr     = '0;
        i_ls_addr    = '0;
        i_ls_wrdata  = '0;
        i_mem_rddata = '0;
        idle_inputs();
        i_f_rd = 1'b1;
        settle();
        chk("rst_mem_rd", 32'(o_mem_rd), 0);
        chk("rst_f_rdvalid", 32'(o_f_rdvalid), 0);
        tick();
        settle();
        chk("rst_ls_rdvalid", 32'(o_ls_rdvalid), 0);
        chk("rst_f_rdvalid2", 32'(o_f_rdvalid), 0);
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();

        // Fetch alone
        i_f_rd = 1'b1; i_f_addr = 16'h0010;
        settle();
        chk("f0_mem_rd", 32'(o_mem_rd), 1);
        chk("f0_mem_addr", 32'(o_mem_addr), 32'h0010);
        chk("f0_f_wait", 32'(o_f_wait), 0);
        chk("f0_mem_wr", 32'(o_mem_wr), 0);
        tick();
        idle_inputs(); i_mem_rddata = 16'h1234;
        settle();
        chk("f1_f_rdvalid", 32'(o_f_rdvalid), 1);
        chk("f1_f_rddata", 32'(o_f_rddata), 32'h1234);
        chk("f1_ls_rdvalid", 32'(o_ls_rdvalid), 0);
        tick();

        // Store beats a simultaneous fetch
        i_f_rd = 1'b1; i_f_addr = 16'h0020;
        i_ls_wr = 1'b1; i_ls_addr = 16'h0100; i_ls_wrdata = 16'hBEEF;
        settle();
        chk("sw0_mem_wr", 32'(o_mem_wr), 1);
        chk("sw0_mem_rd", 32'(o_mem_rd), 0);
        chk("sw0_mem_addr", 32'(o_mem_addr), 32'h0100);
        chk("sw0_wrdata", 32'(o_mem_wrdata), 32'hBEEF);
        chk("sw0_f_wait", 32'(o_f_wait), 1);
        chk("sw0_ls_wait", 32'(o_ls_wait), 0);
        chk("sw0_f_rdvalid", 32'(o_f_rdvalid), 0);
        tick();
        i_ls_wr = 1'b0;
        settle();
        chk("sw1_mem_rd", 32'(o_mem_rd), 1);
        chk("sw1_mem_addr", 32'(o_mem_addr), 32'h0020);
        chk("sw1_f_wait", 32'(o_f_wait), 0);
        chk("sw1_ls_rdvalid", 32'(o_ls_rdvalid), 0);
        tick();
        idle_inputs(); i_mem_rddata = 16'h5555;
        settle();
        chk("sw2_f_rdvalid", 32'(o_f_rdvalid), 1);
        chk("sw2_f_rddata", 32'(o_f_rddata), 32'h5555);
        tick();

        // Load held through 3 wait-states while fetch requests
        i_ls_rd = 1'b1; i_ls_addr = 16'h0200;
        i_f_rd = 1'b1; i_f_addr = 16'h0030;
        i_mem_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hl_mem_addr", 32'(o_mem_addr), 32'h0200);
            chk("hl_mem_rd", 32'(o_mem_rd), 1);
            chk("hl_ls_wait", 32'(o_ls_wait), 1);
            chk("hl_f_wait", 32'(o_f_wait), 1);
            chk("hl_ls_rdvalid", 32'(o_ls_rdvalid), 0);
            tick();
        end
        i_mem_waitrequest = 1'b0;
        settle();
        chk("hl3_mem_addr", 32'(o_mem_addr), 32'h0200);
        chk("hl3_ls_wait", 32'(o_ls_wait), 0);
        chk("hl3_f_wait", 32'(o_f_wait), 1);
        tick();
        i_ls_rd = 1'b0; i_mem_rddata = 16'hA5A5;
        settle();
        chk("hl4_ls_rdvalid", 32'(o_ls_rdvalid), 1);
        chk("hl4_ls_rddata", 32'(o_ls_rddata), 32'hA5A5);
        chk("hl4_f_rdvalid", 32'(o_f_rdvalid), 0);
        chk("hl4_mem_addr", 32'(o_mem_addr), 32'h0030);
        chk("hl4_f_wait", 32'(o_f_wait), 0);
        tick();
        idle_inputs(); i_mem_rddata = 16'h0F0F;
        settle();
        chk("hl5_f_rdvalid", 32'(o_f_rdvalid), 1);
        chk("hl5_ls_rdvalid", 32'(o_ls_rdvalid), 0);
        tick();

        // Fetch held in wait-state keeps the grant against a later load
        i_f_rd = 1'b1; i_f_addr = 16'h0040; i_mem_waitrequest = 1'b1;
        settle();
        chk("hf0_f_wait", 32'(o_f_wait), 1);
        tick();
        i_ls_rd = 1'b1; i_ls_addr = 16'h0300;
        settle();
        chk("hf1_mem_addr", 32'(o_mem_addr), 32'h0040);
        chk("hf1_ls_wait", 32'(o_ls_wait), 1);
        tick();
        i_mem_waitrequest = 1'b0;
        settle();
        chk("hf2_mem_addr", 32'(o_mem_addr), 32'h0040);
        chk("hf2_f_wait", 32'(o_f_wait), 0);
        chk("hf2_ls_wait", 32'(o_ls_wait), 1);
        tick();
        i_f_rd = 1'b0; i_mem_rddata = 16'h4444;
        settle();
        chk("hf3_f_rdvalid", 32'(o_f_rdvalid), 1);
        chk("hf3_mem_addr", 32'(o_mem_addr), 32'h0300);
        chk("hf3_ls_wait", 32'(o_ls_wait), 0);
        tick();
        idle_inputs(); i_mem_rddata = 16'h3333;
        settle();
        chk("hf4_ls_rdvalid", 32'(o_ls_rdvalid), 1);
        chk("hf4_f_rdvalid", 32'(o_f_rdvalid), 0);
        tick();

        // Alternating load/fetch, one per cycle
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin
                i_ls_rd = 1'b1; i_ls_addr = 16'(16'h0400 + i);
            end else begin
                i_f_rd = 1'b1; i_f_addr = 16'(16'h0500 + i);
            end
            i_mem_rddata = 16'(16'hD000 + i);
            settle();
            chk("alt_mem_addr", 32'(o_mem_addr), (i % 2 == 0) ? 32'(16'h0400 + i) : 32'(16'h0500 + i));
            if (i > 0) begin
                chk("alt_ls_rdvalid", 32'(o_ls_rdvalid), (i % 2 == 1) ? 32'd1 : 32'd0);
                chk("alt_f_rdvalid", 32'(o_f_rdvalid), (i % 2 == 0) ? 32'd1 : 32'd0);
                chk("alt_rddata", 32'(o_f_rddata), 32'(16'hD000 + i));
            end
            tick();
        end
        idle_inputs(); i_mem_rddata = 16'hD006;
        settle();
        chk("alt_last_f_rdvalid", 32'(o_f_rdvalid), 1);
        chk("alt_last_ls_rdvalid", 32'(o_ls_rdvalid), 0);
        tick();

        // Read plus write together: write wins, no return
        i_ls_rd = 1'b1; i_ls_wr = 1'b1; i_ls_addr = 16'h0600; i_ls_wrdata = 16'hCAFE;
        settle();
        chk("rw_mem_wr", 32'(o_mem_wr), 1);
        chk("rw_mem_rd", 32'(o_mem_rd), 0);
        tick();
        idle_inputs();
        settle();
        chk("rw_ls_rdvalid", 32'(o_ls_rdvalid), 0);
        tick();

        // Reset right after an accepted read
        i_f_rd = 1'b1; i_f_addr = 16'h0060;
        tick();
        idle_inputs(); reset = 1'b1;
        settle();
        chk("rr_f_rdvalid", 32'(o_f_rdvalid), 0);
        chk("rr_ls_rdvalid", 32'(o_ls_rdvalid), 0);
        tick();
        reset = 1'b0;
        settle();
        chk("rr_f_rdvalid_after", 32'(o_f_rdvalid), 0);
        tick();

        // Reset while holding a load: next fetch is granted from IDLE
        i_ls_rd = 1'b1; i_ls_addr = 16'h0700; i_mem_waitrequest = 1'b1;
        tick();
        idle_inputs(); reset = 1'b1;
        tick();
        reset = 1'b0;
        i_f_rd = 1'b1; i_f_addr = 16'h0070;
        settle();
        chk("rh_mem_addr", 32'(o_mem_addr), 32'h0070);
        chk("rh_f_wait", 32'(o_f_wait), 0);
        chk("rh_ls_rdvalid", 32'(o_ls_rdvalid), 0);
        tick();
        idle_inputs();
        tick();

        // Continuous loads with a pending fetch
        i_ls_rd = 1'b1; i_ls_addr = 16'h0800;
        i_f_rd = 1'b1; i_f_addr = 16'h0900;
        for (int i = 0; i < 7; i++) begin
            settle();
            chk("fair_f_wait", 32'(o_f_wait), (FAIR && i == 4) ? 32'd0 : 32'd1);
            chk("fair_ls_wait", 32'(o_ls_wait), (FAIR && i == 4) ? 32'd1 : 32'd0);
            chk("fair_mem_addr", 32'(o_mem_addr), (FAIR && i == 4) ? 32'h0900 : 32'h0800);
            tick();
        end
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
